// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : seq_multiplier
// Purpose : Shift-add sequential multiplier, signed or unsigned operands,
//           one multiplier bit per RUN cycle, fully registered outputs.
// Revision: 1.0 - initial release
// ============================================================================
module seq_multiplier #(
   parameter int WIDTH = 5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   is_signed,
   input  logic [WIDTH-1:0]       a,
   input  logic [WIDTH-1:0]       b,
   output logic                   busy,
   output logic                   done,
   output logic [2*WIDTH-1:0]     result
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic                 sign_q, sign_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic [2*WIDTH-1:0]   addend;
   logic [2*WIDTH-1:0]   acc_next;
   logic                 last_bit;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      acc_d    = acc_q;
      result_d = result_q;
      addend   = '0;
      acc_next = acc_q;
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RUN;
               mcand_d  = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
               mplier_d = b;
               sign_d   = is_signed;
               acc_d    = '0;
               cnt_d    = '0;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            addend = mplier_q[0] ? mcand_q : '0;
            // In two's complement the multiplier MSB carries negative weight.
            if (sign_q && last_bit) begin
               acc_next = acc_q - addend;
            end else begin
               acc_next = acc_q + addend;
            end
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (last_bit) begin
               state_d  = DONE;
               cnt_d    = '0;
               result_d = acc_next;
            end else begin
               cnt_d    = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;

endmodule
`default_nettype wire
